// File: rtl/pitch_detect_scheduler_pkg.sv
// Shared types and helpers for the two-channel pitch detector scheduler.
package pitch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } sched_state_t;

  typedef logic chan_t;

  localparam int DROP_W = 16;

  // Saturating add of 0..2 dropped beats onto the drop counter.
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a, input logic [1:0] b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/pitch_detect_scheduler_if.sv
// Valid/ready streaming bus used on every data port of the scheduler.
interface Axis_If #(parameter int DWIDTH = 24);
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;

  modport master(output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/pitch_detect_scheduler_rr_pick2.sv
// Two-request round-robin picker: prio breaks ties, a lone request always wins.
module rr_pick2
  import pitch_sched_pkg::*;
(
  input  logic [1:0] req,
  input  chan_t      prio,
  output chan_t      grant,
  output logic       any
);

  assign any   = |req;
  assign grant = (&req) ? prio : req[1];

endmodule

// File: rtl/pitch_detect_scheduler.sv
// Time-shares one pitch detector between two channels, whole frames at a time, round-robin.
// Optional WAIT timeout is enabled by defining PITCH_SCHED_TIMEOUT_EN.
module pitch_detect_scheduler
  import pitch_sched_pkg::*;
#(
  parameter int DWIDTH         = 24,
  parameter int FRAME_LEN      = 2048,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  Axis_If.slave             ch_in [2],
  Axis_If.master            det_in,
  Axis_If.slave             det_pitch,
  Axis_If.master            pitch_out,
  output chan_t             pitch_ch,
  output logic              pitch_err,
  output logic [DROP_W-1:0] drop_count
);

  localparam int BW = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FEED = FEED;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_EMIT = EMIT;

  if (FRAME_LEN < 2 || (FRAME_LEN & (FRAME_LEN - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("pitch_detect_scheduler: FRAME_LEN must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]        state;
  chan_t             sel;
  chan_t             prio;
  chan_t             grant;
  logic              any;
  logic [BW-1:0]     beat_cnt;
  logic [DWIDTH-1:0] res_q;
  logic              feed;
  logic              drop0;
  logic              drop1;
  logic [1:0]        drop_inc;
  logic [1:0]        req;

`ifdef PITCH_SCHED_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        err_q;
  assign pitch_err = err_q;
`else
  assign pitch_err = 1'b0;
`endif

  assign req = {ch_in[1].valid, ch_in[0].valid};

  rr_pick2 u_pick (
    .req   (req),
    .prio  (prio),
    .grant (grant),
    .any   (any)
  );

  assign feed = (state == ST_FEED);

  // Selected channel is wired straight through so FEED has no bubble.
  assign det_in.data     = sel ? ch_in[1].data : ch_in[0].data;
  assign det_in.valid    = feed && (sel ? ch_in[1].valid : ch_in[0].valid);
  assign ch_in[0].ready  = (feed && !sel) ? det_in.ready : 1'b1;
  assign ch_in[1].ready  = (feed &&  sel) ? det_in.ready : 1'b1;

  assign det_pitch.ready = (state == ST_WAIT);
  assign pitch_out.valid = (state == ST_EMIT);
  assign pitch_out.data  = res_q;
  assign pitch_ch        = sel;

  // Any valid beat not routed to the detector is consumed and discarded.
  assign drop0    = ch_in[0].valid && !(feed && !sel);
  assign drop1    = ch_in[1].valid && !(feed &&  sel);
  assign drop_inc = {1'b0, drop0} + {1'b0, drop1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      prio       <= 1'b0;
      beat_cnt   <= '0;
      res_q      <= '0;
      drop_count <= '0;
`ifdef PITCH_SCHED_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      drop_count <= sat_add(drop_count, drop_inc);
      case (state)
        ST_IDLE: begin
          if (any) begin
            sel   <= grant;
            state <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (det_in.valid && det_in.ready) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_WAIT;
`ifdef PITCH_SCHED_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        ST_WAIT: begin
          // A real result beats a timeout landing on the same cycle.
          if (det_pitch.valid) begin
            res_q <= det_pitch.data;
`ifdef PITCH_SCHED_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            state <= ST_EMIT;
          end
`ifdef PITCH_SCHED_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            res_q <= '0;
            err_q <= 1'b1;
            state <= ST_EMIT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        ST_EMIT: begin
          if (pitch_out.ready) begin
            prio  <= ~sel;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_detect_scheduler.sv
// Bench for pitch_detect_scheduler: table-driven frames, directed corners and a random run vs a frame-level model.
module tb_pitch_detect_scheduler;
  import pitch_sched_pkg::*;

  localparam int DW = 24;
  localparam int FL = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  Axis_If #(.DWIDTH(DW)) ch_in [2] ();
  Axis_If #(.DWIDTH(DW)) det_in ();
  Axis_If #(.DWIDTH(DW)) det_pitch ();
  Axis_If #(.DWIDTH(DW)) pitch_out ();
  chan_t       pitch_ch;
  logic        pitch_err;
  logic [15:0] drop_count;

  pitch_detect_scheduler #(.DWIDTH(DW), .FRAME_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_in      (ch_in),
    .det_in     (det_in),
    .det_pitch  (det_pitch),
    .pitch_out  (pitch_out),
    .pitch_ch   (pitch_ch),
    .pitch_err  (pitch_err),
    .drop_count (drop_count)
  );

  typedef struct packed {logic [23:0] dat; logic ch; logic err;} res_t;
  typedef struct {bit v0; bit v1; logic [23:0] res; bit exp_ch;} vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus policy
  int v_mode [2];          // 0 idle, 1 always, 2 random, 3 only until frame is fed
  int din_rdy_mode;        // 1 always ready, 2 random
  int pout_mode;           // 0 stall, 1 ready, 2 random
  int det_delay;
  bit det_respond;
  bit det_early;
  logic [23:0] det_val;
  int seq [2];

  // detector stub
  bit          stub_on;
  int          stub_cnt;
  logic [23:0] stub_val;

  // frame-level reference model: 0 idle, 1 feeding, 2 awaiting result, 3 result offered
  int     m_phase;
  chan_t  m_sel;
  chan_t  m_prio;
  int     m_beats;
  int     m_wait;
  longint acc_total;
  longint fed_total;
  res_t   exp_q [$];
  int     frames_done = 0;
  res_t   last_out;
  logic [15:0] last_drop;
  int     wait_entry_cyc, emit_entry_cyc, hs_wait_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit pick_v(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return (m_phase <= 1);
    endcase
  endfunction

  task automatic reset_model();
    m_phase = 0; m_sel = 1'b0; m_prio = 1'b0; m_beats = 0; m_wait = 0;
    acc_total = 0; fed_total = 0;
    exp_q.delete();
    stub_on = 1'b0; stub_cnt = 0;
  endtask

  task automatic drive();
    ch_in[0].valid  = pick_v(v_mode[0]);
    ch_in[0].data   = {1'b0, 23'(seq[0])};
    ch_in[1].valid  = pick_v(v_mode[1]);
    ch_in[1].data   = {1'b1, 23'(seq[1])};
    det_in.ready    = (din_rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    det_pitch.valid = stub_on;
    det_pitch.data  = stub_val;
    pitch_out.ready = (pout_mode == 2) ? 1'($urandom_range(0, 1)) : (pout_mode == 1);
  endtask

  task automatic sample();
    bit hs0, hs1, hsd, hsp, hso;
    logic [4:0] e_ctl;
    longint diff;
    hs0 = ch_in[0].valid && ch_in[0].ready;
    hs1 = ch_in[1].valid && ch_in[1].ready;
    hsd = det_in.valid && det_in.ready;
    hsp = det_pitch.valid && det_pitch.ready;
    hso = pitch_out.valid && pitch_out.ready;

    // {ch0.ready, ch1.ready, det_in.valid, det_pitch.ready, pitch_out.valid}
    e_ctl = 5'b11000;
    case (m_phase)
      1: if (m_sel == 1'b0) begin e_ctl[4] = det_in.ready; e_ctl[2] = ch_in[0].valid; end
         else begin e_ctl[3] = det_in.ready; e_ctl[2] = ch_in[1].valid; end
      2: e_ctl[1] = 1'b1;
      3: e_ctl[0] = 1'b1;
      default: ;
    endcase
    chk("ctrl", {ch_in[0].ready, ch_in[1].ready, det_in.valid, det_pitch.ready, pitch_out.valid}, e_ctl);
    diff = acc_total - fed_total;
    chk("drop_count", drop_count, (diff > 65535) ? 65535 : diff);
    if (hsd && m_phase == 1) chk("det_in_dat", det_in.data, {m_sel, 23'(seq[m_sel])});
    if (pitch_out.valid && exp_q.size() > 0)
      chk("pitch_out", {pitch_out.data, pitch_ch, pitch_err}, {exp_q[0].dat, exp_q[0].ch, exp_q[0].err});

    acc_total += longint'(hs0) + longint'(hs1);
    if (hsd) fed_total++;
    if (hs0) seq[0]++;
    if (hs1) seq[1]++;

    if (hsp) stub_on = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) stub_on = 1'b1;
    end

    case (m_phase)
      0: if (ch_in[0].valid || ch_in[1].valid) begin
           m_sel   = (ch_in[0].valid && ch_in[1].valid) ? m_prio : chan_t'(ch_in[1].valid);
           m_phase = 1;
           m_beats = 0;
           if (det_respond && det_early) begin stub_on = 1'b1; stub_val = det_val; end
         end
      1: if (hsd) begin
           m_beats++;
           if (m_beats == FL) begin
             m_phase = 2; m_wait = 0; wait_entry_cyc = cyc + 1;
             if (det_respond && !det_early) begin
               stub_val = det_val;
               if (det_delay == 0) stub_on = 1'b1;
               else stub_cnt = det_delay;
             end
           end
         end
      2: if (hsp) begin
           exp_q.push_back('{dat: stub_val, ch: m_sel, err: 1'b0});
           hs_wait_len = m_wait; m_phase = 3; emit_entry_cyc = cyc + 1;
         end else begin
           m_wait++;
`ifdef PITCH_SCHED_TIMEOUT_EN
           if (m_wait == TO) begin
             exp_q.push_back('{dat: 24'h0, ch: m_sel, err: 1'b1});
             m_phase = 3; emit_entry_cyc = cyc + 1;
           end
`endif
         end
      3: if (hso) begin
           last_out  = '{dat: pitch_out.data, ch: pitch_ch, err: pitch_err};
           last_drop = drop_count;
           m_prio    = ~m_sel;
           m_phase   = 0;
           void'(exp_q.pop_front());
           frames_done++;
         end
      default: ;
    endcase
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    #3 sample();
  endtask

  task automatic run_frames(input int n, input int budget);
    int target = frames_done + n;
    int c = 0;
    while (frames_done < target && c < budget) begin step(); c++; end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL frame_budget actual=%0d frames required=%0d", frames_done, target);
    end
  endtask

  task automatic run_to_phase(input int ph, input int budget);
    int c = 0;
    while (m_phase != ph && c < budget) begin step(); c++; end
    chk("reach_phase", m_phase, ph);
  endtask

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 24'h111111, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 24'h222222, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 24'h333333, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 24'h444444, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 24'h555555, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 24'h666666, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 24'h777777, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 24'h888888, 1'b0};

    v_mode[0] = 0; v_mode[1] = 0; din_rdy_mode = 1; pout_mode = 1;
    det_delay = 5; det_respond = 1'b1; det_early = 1'b0; det_val = 24'h000ABC;
    seq[0] = 0; seq[1] = 0; stub_val = '0;
    reset_model();
    drive();
    #12;
    chk("rst_ctrl", {ch_in[0].ready, ch_in[1].ready, det_in.valid, det_pitch.ready, pitch_out.valid}, 5'b11000);
    chk("rst_drop", drop_count, 0);
    chk("rst_err", pitch_err, 0);
    @(negedge clk) reset = 1'b1;

    // single channel frame
    v_mode[0] = 3;
    run_frames(1, 200);
    chk("single_out", last_out, {24'h000ABC, 1'b0, 1'b0});
    chk("single_drop", last_drop, 1);
    chk("single_fed", fed_total, FL);

    // channel selection / alternation table
    for (int i = 0; i < 8; i++) begin
      v_mode[0] = tbl[i].v0 ? 1 : 0;
      v_mode[1] = tbl[i].v1 ? 1 : 0;
      det_val   = tbl[i].res;
      run_frames(1, 300);
      chk("tbl_ch", last_out.ch, tbl[i].exp_ch);
      chk("tbl_dat", last_out.dat, tbl[i].res);
    end

    // detector backpressure
    v_mode[0] = 2; v_mode[1] = 2; din_rdy_mode = 2; det_val = 24'h0F0F0F;
    run_frames(3, 3000);
    din_rdy_mode = 1;

    // result offered during FEED is taken on the first WAIT cycle
    v_mode[0] = 1; v_mode[1] = 1; det_early = 1'b1; det_val = 24'hE00001;
    run_frames(1, 300);
    chk("early_consume", hs_wait_len, 0);
    det_early = 1'b0;

    // output stall: 20 cycles, both channels valid
    begin
      logic [15:0] d_a;
      det_val = 24'h5A5A5A; pout_mode = 0;
      run_to_phase(3, 300);
      step();
      d_a = drop_count;
      repeat (20) step();
      chk("stall_drops", drop_count - d_a, 40);
      chk("stall_dat", {pitch_out.data, pitch_out.valid}, {24'h5A5A5A, 1'b1});
      pout_mode = 1;
      run_frames(1, 50);
    end

    // unresponsive detector
    v_mode[0] = 3; v_mode[1] = 0; det_respond = 1'b0;
`ifdef PITCH_SCHED_TIMEOUT_EN
    run_frames(1, 400);
    chk("timeout_lat", emit_entry_cyc - wait_entry_cyc, TO);
    chk("timeout_out", {last_out.dat, last_out.err}, {24'h0, 1'b1});
`else
    run_to_phase(2, 300);
    repeat (100) step();
    chk("wait_hold_pv", pitch_out.valid, 0);
    chk("wait_hold_pr", det_pitch.ready, 1);
    stub_val = 24'h123456; stub_on = 1'b1;
    run_frames(1, 20);
    chk("late_out", {last_out.dat, last_out.err}, {24'h123456, 1'b0});
`endif
    det_respond = 1'b1;

    // reset in the middle of a frame
    v_mode[0] = 1; v_mode[1] = 1; det_val = 24'hC0FFEE;
    begin
      int c = 0;
      while (!(m_phase == 1 && m_beats == 3) && c < 300) begin step(); c++; end
      chk("mid_feed_reached", m_beats, 3);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ctrl", {ch_in[0].ready, ch_in[1].ready, det_in.valid, det_pitch.ready, pitch_out.valid}, 5'b11000);
    chk("midrst_drop", drop_count, 0);
    chk("midrst_err", pitch_err, 0);
    ch_in[0].valid = 1'b0; ch_in[1].valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    reset_model();
    run_frames(1, 300);
    chk("post_reset_fed", fed_total, FL);
    chk("post_reset_dat", last_out.dat, 24'hC0FFEE);

    // random frames
    for (int f = 0; f < 12; f++) begin
      v_mode[0] = $urandom_range(1, 2); v_mode[1] = $urandom_range(1, 2);
      din_rdy_mode = $urandom_range(1, 2); pout_mode = $urandom_range(1, 2);
      det_delay = $urandom_range(0, 10); det_early = 1'($urandom_range(0, 1));
      det_val = 24'($urandom);
      run_frames(1, 600);
    end
    det_early = 1'b0; din_rdy_mode = 1;

    // drop counter saturation via long output stall
    v_mode[0] = 1; v_mode[1] = 1; pout_mode = 0; det_val = 24'hABCDEF;
    run_to_phase(3, 300);
    repeat (32800) step();
    chk("sat", drop_count, 16'hFFFF);
    pout_mode = 1;
    run_frames(1, 300);
    chk("sat_hold", drop_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
